// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 code-lock slice:
//   lock_state_t  - code-lock FSM states
//   SC_BREAK      - break prefix scan code (F0 xx = key released)
//   SC_EXT        - extended prefix scan code (E0)
//   max_int       - helper used to size the shared duration timer
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        SKIP    = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
// Loadable down counter that saturates at zero. After a load of N the
// expired_o flag is high during the N-th cycle following the load cycle,
// for exactly one cycle, so "N cycles have elapsed" can be acted on
// directly in that cycle. A zero count means idle (no further expiry).
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset (count cleared)
//   load_i     in  load value_i into the counter this cycle
//   value_i    in  WIDTH-bit reload value
//   expired_o  out one-cycle pulse when the loaded duration has elapsed
// ---------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    // The last counted cycle is the one where the count reads 1.
    assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/ps2_code_lock.sv
// ---------------------------------------------------------------------------
// ps2_code_lock
// Code-lock engine sitting behind the PS/2 receive FIFO (sys_clk domain).
// Collects CODE_LEN make codes (break and extended prefixes skipped),
// compares the entry with a programmable password, opens for OPEN_CYCLES
// on a match, and after MAX_FAILS consecutive failures discards all input
// for LOCKOUT_CYCLES. A partial entry left idle for TIMEOUT_CYCLES is
// abandoned without counting a failure.
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   code_valid  in  FIFO holds a scan code
//   code        in  scan code at the FIFO head
//   code_ready  out FIFO read enable; byte consumed when valid & ready
//   password    in  [CODE_LEN-1:0][7:0], [0] is the first key
//   progress    out thermometer of accepted keys in the current entry
//   unlocked    out high for exactly OPEN_CYCLES after a match
//   locked_out  out high during lockout
//   fail_count  out consecutive failed entries, saturating at MAX_FAILS
// ---------------------------------------------------------------------------
module ps2_code_lock
    import ps2_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 1000,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             code_valid,
    input  logic [7:0]                       code,
    output logic                             code_ready,
    input  logic [CODE_LEN-1:0][7:0]         password,
    output logic [CODE_LEN-1:0]              progress,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int DUR_W  = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES)) + 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int KW     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    lock_state_t                 state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [CODE_LEN-1:0]         progress_q, progress_d;
    logic [CODE_LEN-1:0][7:0]    entry_q, entry_d;
    logic [FAIL_W-1:0]           fail_q, fail_d;

    logic                        accept;
    logic                        tmo_load;
    logic                        tmo_expired;
    logic                        dur_load;
    logic [DUR_W-1:0]            dur_value;
    logic                        dur_expired;

    // The FIFO must not be drained while reset is held, so ready is gated
    // by rst as well as by state (the async reset only parks the state).
    assign code_ready = !rst && ((state_q == COLLECT) || (state_q == SKIP) ||
                                 (state_q == LOCKOUT));
    assign accept     = code_valid && code_ready;

    // Inter-key timeout: restarted by every byte consumed while an entry is
    // being collected, so a byte landing in the expiry cycle wins.
    down_timer #(.WIDTH(TMO_W)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmo_load),
        .value_i   (TMO_W'(TIMEOUT_CYCLES)),
        .expired_o (tmo_expired)
    );

    // OPEN and LOCKOUT never overlap, so one timer serves both durations.
    down_timer #(.WIDTH(DUR_W)) u_duration (
        .clk       (clk),
        .rst       (rst),
        .load_i    (dur_load),
        .value_i   (dur_value),
        .expired_o (dur_expired)
    );

    // Next-state logic for the lock FSM, entry buffer and failure counter.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        progress_d = progress_q;
        entry_d    = entry_q;
        fail_d     = fail_q;
        tmo_load   = 1'b0;
        dur_load   = 1'b0;
        dur_value  = '0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    tmo_load = 1'b1;
                    if (code == SC_BREAK) begin
                        state_d = SKIP;
                    end else if (code != SC_EXT) begin
                        entry_d[k_q]    = code;
                        progress_d[k_q] = 1'b1;
                        if (k_q == KW'(CODE_LEN - 1)) begin
                            state_d = CHECK;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end else if (tmo_expired && (k_q != '0)) begin
                    k_d        = '0;
                    progress_d = '0;
                end
            end

            SKIP: begin
                if (accept) begin
                    tmo_load = 1'b1;
                    state_d  = COLLECT;
                end else if (tmo_expired && (k_q != '0)) begin
                    k_d        = '0;
                    progress_d = '0;
                    state_d    = COLLECT;
                end
            end

            CHECK: begin
                k_d        = '0;
                progress_d = '0;
                if (entry_q == password) begin
                    fail_d    = '0;
                    state_d   = OPEN;
                    dur_load  = 1'b1;
                    dur_value = DUR_W'(OPEN_CYCLES);
                end else if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
                    fail_d    = FAIL_W'(MAX_FAILS);
                    state_d   = LOCKOUT;
                    dur_load  = 1'b1;
                    dur_value = DUR_W'(LOCKOUT_CYCLES);
                end else begin
                    fail_d  = fail_q + FAIL_W'(1);
                    state_d = COLLECT;
                end
            end

            OPEN: begin
                if (dur_expired) begin
                    state_d = COLLECT;
                end
            end

            LOCKOUT: begin
                if (dur_expired) begin
                    fail_d  = '0;
                    state_d = COLLECT;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            k_q        <= '0;
            progress_q <= '0;
            entry_q    <= '0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            progress_q <= progress_d;
            entry_q    <= entry_d;
            fail_q     <= fail_d;
        end
    end

    assign progress   = progress_q;
    assign unlocked   = (state_q == OPEN);
    assign locked_out = (state_q == LOCKOUT);
    assign fail_count = fail_q;

endmodule

// File: tb/tb_ps2_code_lock.sv
// ---------------------------------------------------------------------------
// tb_ps2_code_lock
// Scoreboard bench for ps2_code_lock. A reference model tracks the lock at
// the level of "list of keys typed so far", "unlocked until cycle X",
// "locked until cycle Y" and pushes the expected outputs for every cycle
// into a queue; an independent monitor pops and compares on the falling
// edge. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_ps2_code_lock;

    localparam int CL = 4;
    localparam int MF = 3;
    localparam int OC = 8;
    localparam int LC = 20;
    localparam int TC = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                code_valid;
    logic [7:0]          code;
    logic                code_ready;
    logic [CL-1:0][7:0]  password;
    logic [CL-1:0]       progress;
    logic                unlocked;
    logic                locked_out;
    logic [1:0]          fail_count;

    ps2_code_lock #(
        .CODE_LEN       (CL),
        .MAX_FAILS      (MF),
        .OPEN_CYCLES    (OC),
        .LOCKOUT_CYCLES (LC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .password   (password),
        .progress   (progress),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CL-1:0] progress;
        bit            unlocked;
        bit            locked;
        int            fails;
        bit            ready;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  pw [CL] = '{8'h2C, 8'h24, 8'h1B, 8'h2C};
    logic [7:0]  keys[$];
    bit          skipNext     = 1'b0;
    bit          checkPending = 1'b0;
    bit          mAccepted    = 1'b0;
    int          fails        = 0;
    longint      cyc          = 0;
    longint      openUntil    = 0;
    longint      lockUntil    = 0;
    longint      lastRestart  = 0;
    int          checkCount   = 0;
    int          passCount    = 0;

    function automatic logic [CL-1:0] therm(input int n);
        logic [CL-1:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t[i] = 1'b1;
        return t;
    endfunction

    // Reference model: one step per clock, based only on the inputs.
    always @(posedge clk) begin : refModel
        bit   inOpen, inLock, ready, acc, match;
        exp_t e;
        inOpen    = cyc < openUntil;
        inLock    = cyc < lockUntil;
        ready     = !checkPending && !inOpen;
        acc       = code_valid && ready && !rst;
        mAccepted = acc;
        if (rst) begin
            keys.delete();
            skipNext     = 1'b0;
            checkPending = 1'b0;
            fails        = 0;
            openUntil    = 0;
            lockUntil    = 0;
            lastRestart  = 0;
        end else if (checkPending) begin
            match = 1'b1;
            for (int i = 0; i < CL; i++) if (keys[i] != pw[i]) match = 1'b0;
            keys.delete();
            checkPending = 1'b0;
            skipNext     = 1'b0;
            if (match) begin
                fails     = 0;
                openUntil = cyc + 1 + OC;
            end else begin
                fails++;
                if (fails == MF) lockUntil = cyc + 1 + LC;
            end
        end else if (inLock) begin
            if (cyc == lockUntil - 1) fails = 0;
        end else if (!inOpen) begin
            if (acc) begin
                lastRestart = cyc;
                if (skipNext) skipNext = 1'b0;
                else if (code == 8'hF0) skipNext = 1'b1;
                else if (code != 8'hE0) begin
                    keys.push_back(code);
                    if (keys.size() == CL) checkPending = 1'b1;
                end
            end else if (keys.size() > 0 && (cyc - lastRestart) == TC) begin
                keys.delete();
                skipNext = 1'b0;
            end
        end
        cyc++;
        e.progress = therm(keys.size());
        e.unlocked = cyc < openUntil;
        e.locked   = cyc < lockUntil;
        e.fails    = fails;
        e.ready    = !checkPending && !(cyc < openUntil);
        expQ.push_back(e);
    end

    task automatic checkOutput(input string name, input exp_t e);
        checkCount++;
        if (progress === e.progress && unlocked === e.unlocked &&
            locked_out === e.locked && int'(fail_count) == e.fails &&
            code_ready === e.ready) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s t=%0t got prog=%b unl=%b lock=%b fc=%0d rdy=%b need prog=%b unl=%b lock=%b fc=%0d rdy=%b",
                     name, $time, progress, unlocked, locked_out, fail_count, code_ready,
                     e.progress, e.unlocked, e.locked, e.fails, e.ready);
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation each cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (rst) begin
                e.progress = '0;
                e.unlocked = 1'b0;
                e.locked   = 1'b0;
                e.fails    = 0;
                e.ready    = 1'b0;
            end
            checkOutput("cycle", e);
        end
    end

    // Present one byte after 'idle' empty cycles and hold it until consumed.
    task automatic applyStimulus(input logic [7:0] b, input int idle);
        int waited;
        code_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        code       = b;
        code_valid = 1'b1;
        waited     = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!mAccepted && waited < 200);
        if (!mAccepted) begin
            checkCount++;
            $display("[TB] FAIL accept_wait byte=%h got not consumed need consumed within 200 cycles", b);
        end
        code_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendPassword();
        for (int i = 0; i < CL; i++) applyStimulus(pw[i], 0);
    endtask

    task automatic sendWrong();
        for (int i = 0; i < CL; i++) applyStimulus(8'h1C, 0);
    endtask

    // Asynchronous reset mid-cycle: outputs must drop before any edge.
    task automatic doReset();
        exp_t z;
        z.progress = '0;
        z.unlocked = 1'b0;
        z.locked   = 1'b0;
        z.fails    = 0;
        z.ready    = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", z);
        waitCycles(3);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog got no finish need finish within 100000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] rb;
        int         sel;
        rst        = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        for (int i = 0; i < CL; i++) password[i] = pw[i];
        waitCycles(3);
        rst = 1'b0;
        waitCycles(2);

        $display("[TB] correct entry");
        sendPassword();
        waitCycles(12);

        $display("[TB] entry with break and extended prefixes");
        applyStimulus(8'h2C, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h2C, 0);
        applyStimulus(8'h24, 0); applyStimulus(8'hE0, 0); applyStimulus(8'h1B, 0);
        applyStimulus(8'hF0, 0); applyStimulus(8'h1B, 0); applyStimulus(8'h2C, 0);
        waitCycles(12);

        $display("[TB] three failures into lockout");
        sendWrong(); sendWrong(); sendWrong();
        applyStimulus(8'h2C, 1); applyStimulus(8'h24, 2); applyStimulus(8'h33, 3);
        waitCycles(25);

        $display("[TB] timeout abandons partial entry");
        applyStimulus(8'h2C, 0); applyStimulus(8'h24, 0);
        waitCycles(20);
        sendPassword();
        waitCycles(12);

        $display("[TB] byte in the exact expiry cycle");
        applyStimulus(8'h2C, 0); applyStimulus(8'h24, 0);
        applyStimulus(8'h1B, TC - 1);
        applyStimulus(8'h2C, TC);
        waitCycles(4);
        sendPassword();
        waitCycles(12);

        $display("[TB] reset during OPEN and LOCKOUT");
        sendPassword();
        waitCycles(3);
        doReset();
        sendWrong(); sendWrong(); sendWrong();
        waitCycles(5);
        doReset();
        sendPassword();
        waitCycles(12);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                for (int i = 0; i < CL; i++) begin
                    if ($urandom_range(0, 3) == 0) applyStimulus(8'hE0, $urandom_range(0, 2));
                    if ($urandom_range(0, 3) == 0) begin
                        applyStimulus(8'hF0, 0);
                        applyStimulus(8'(pw[$urandom_range(0, CL - 1)]), 0);
                    end
                    applyStimulus(pw[i], $urandom_range(0, 4));
                end
            end else if (sel < 9) begin
                for (int j = 0; j < 3; j++) begin
                    case ($urandom_range(0, 6))
                        0: rb = 8'hE0;
                        1: rb = 8'hF0;
                        2: rb = 8'h1C;
                        3: rb = pw[$urandom_range(0, CL - 1)];
                        default: rb = 8'($urandom_range(0, 255));
                    endcase
                    applyStimulus(rb, ($urandom_range(0, 4) == 0) ? $urandom_range(TC - 2, TC + 2)
                                                                  : $urandom_range(0, 3));
                end
            end else begin
                waitCycles($urandom_range(0, 10));
                doReset();
            end
        end
        code_valid = 1'b0;
        waitCycles(40);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
